// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - TM1638 command bytes, key reader states and key decode helper
package tm1638_pkg;

    localparam logic [7:0] CMD_READ_KEYS   = 8'h42;
    localparam logic [7:0] CMD_WRITE_FIXED = 8'h44;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'h8F;
    localparam logic [7:0] CMD_ADDR_BASE   = 8'hC0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        WAIT,
        READ
    } kr_state_t;

    // Each scan byte carries two keys: bit 0 -> key k, bit 4 -> key k+4.
    function automatic logic [7:0] decode_keys(input logic [31:0] raw);
        logic [7:0] k;
        for (int i = 0; i < 4; i++) begin
            k[i]     = raw[8*i];
            k[i + 4] = raw[8*i + 4];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_bit_engine.sv
// rtl/tm1638_bit_engine.sv - LSB-first serial bit engine generating sclk for TM1638 transfers
// Shifts i_data out on o_dout and samples i_din at every rising sclk; sclk idles high.
module tm1638_bit_engine #(
    parameter int HALF_PERIOD = 1,
    parameter int W           = 32,
    localparam int BW         = $clog2(W + 1)
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          i_start,
    input  logic [BW-1:0] i_nbits,
    input  logic [W-1:0]  i_data,
    input  logic          i_din,
    output logic          o_sclk,
    output logic          o_dout,
    output logic          o_done,
    output logic [W-1:0]  o_data
);

    localparam int CW = $clog2(HALF_PERIOD + 1);

    logic          r_active;
    logic          r_high;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit;
    logic [BW-1:0] r_nbits;
    logic [W-1:0]  r_shift;
    logic          r_sclk;
    logic          r_dout;
    logic          w_half_end;
    logic          w_last;

    assign w_half_end = r_active && (r_cnt == CW'(HALF_PERIOD - 1));
    assign w_last     = (r_bit == r_nbits - 1'b1);
    // Combinational so the owner can change state on the very edge the last high phase ends.
    assign o_done     = w_half_end && r_high && w_last;
    assign o_sclk     = r_sclk;
    assign o_dout     = r_dout;
    assign o_data     = r_shift;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_high   <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_nbits  <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b1;
            r_dout   <= 1'b0;
        end else if (i_start && !r_active) begin
            r_active <= 1'b1;
            r_high   <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_nbits  <= i_nbits;
            r_shift  <= i_data;
            r_sclk   <= 1'b0;
            r_dout   <= i_data[0];
        end else if (r_active) begin
            if (w_half_end) begin
                r_cnt <= '0;
                if (!r_high) begin
                    r_high  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_shift <= {i_din, r_shift[W-1:1]};
                end else if (w_last) begin
                    r_active <= 1'b0;
                    r_high   <= 1'b0;
                    r_dout   <= 1'b0;
                end else begin
                    r_high <= 1'b0;
                    r_sclk <= 1'b0;
                    r_bit  <= r_bit + 1'b1;
                    r_dout <= r_shift[0];
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm1638_key_reader.sv
// rtl/tm1638_key_reader.sv - TM1638 key scan: sends read-keys command, reads 4 bytes, decodes 8 keys
import tm1638_pkg::*;

module tm1638_key_reader #(
    parameter int HALF_PERIOD = 1,
    parameter int T_WAIT      = 2
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        stb,
    output logic        sclk,
    output logic        dio_out,
    output logic        dio_oe,
    input  logic        dio_in,
    output logic [31:0] raw_scan,
    output logic [7:0]  keys,
    output logic        key_valid,
    output logic [7:0]  key_press
);

    localparam int WW = $clog2(T_WAIT + 1);

    kr_state_t     r_state;
    kr_state_t     w_next;
    logic [WW-1:0] r_wait;
    logic [31:0]   r_raw;
    logic [7:0]    r_keys;
    logic          r_key_valid;
    logic [7:0]    r_key_press;
    logic          w_eng_start;
    logic [5:0]    w_eng_nbits;
    logic [31:0]   w_eng_load;
    logic          w_eng_done;
    logic          w_eng_sclk;
    logic          w_eng_dout;
    logic [31:0]   w_eng_data;
    logic [7:0]    w_new_keys;

    tm1638_bit_engine #(
        .HALF_PERIOD (HALF_PERIOD),
        .W           (32)
    ) u_engine (
        .clk1    (clk1),
        .reset   (reset),
        .i_start (w_eng_start),
        .i_nbits (w_eng_nbits),
        .i_data  (w_eng_load),
        .i_din   (dio_in),
        .o_sclk  (w_eng_sclk),
        .o_dout  (w_eng_dout),
        .o_done  (w_eng_done),
        .o_data  (w_eng_data)
    );

    assign w_new_keys = decode_keys(w_eng_data);

    always_comb begin
        w_next      = r_state;
        w_eng_start = 1'b0;
        w_eng_nbits = 6'd32;
        w_eng_load  = '0;
        case (r_state)
            IDLE:  if (start) w_next = SETUP;
            SETUP: begin
                w_next      = CMD;
                w_eng_start = 1'b1;
                w_eng_nbits = 6'd8;
                w_eng_load  = {24'd0, CMD_READ_KEYS};
            end
            CMD:   if (w_eng_done) w_next = WAIT;
            WAIT:  if (r_wait == WW'(T_WAIT - 1)) begin
                w_next      = READ;
                w_eng_start = 1'b1;
            end
            READ:  if (w_eng_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_raw       <= '0;
            r_keys      <= '0;
            r_key_valid <= 1'b0;
            r_key_press <= '0;
        end else begin
            r_state     <= w_next;
            r_key_valid <= 1'b0;
            r_key_press <= '0;
            if (r_state == WAIT) r_wait <= r_wait + 1'b1;
            else                 r_wait <= '0;
            if (r_state == READ && w_eng_done) begin
                r_raw       <= w_eng_data;
                r_keys      <= w_new_keys;
                r_key_valid <= 1'b1;
                r_key_press <= w_new_keys & ~r_keys;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign stb       = (r_state == IDLE);
    assign sclk      = w_eng_sclk;
    assign dio_out   = (r_state == CMD) & w_eng_dout;
    assign dio_oe    = (r_state == SETUP) || (r_state == CMD);
    assign raw_scan  = r_raw;
    assign keys      = r_keys;
    assign key_valid = r_key_valid;
    assign key_press = r_key_press;

endmodule
